// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg: shared constants and state encoding for the round-robin arbiter
package rr_arbiter4_pkg;
  localparam int NUM_REQ = 4;
  localparam int MAX_HOLD_DEF = 8;
  localparam int CNT_W_DEF = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between four clients and the arbiter
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0] gnt_id;
  logic gnt_valid;
  modport master(output req, input gnt, gnt_id, gnt_valid);
  modport slave(input req, output gnt, gnt_id, gnt_valid);
endinterface

// File: rtl/rr_arbiter4_dec2to4_onehot.sv
// dec2to4_onehot: 2-bit index to 4-bit one-hot built from plain gate operators
module dec2to4_onehot (
  input  logic [1:0] idx_i,
  output logic [3:0] onehot_o
);
  assign onehot_o[0] = ~idx_i[1] & ~idx_i[0];
  assign onehot_o[1] = ~idx_i[1] &  idx_i[0];
  assign onehot_o[2] =  idx_i[1] & ~idx_i[0];
  assign onehot_o[3] =  idx_i[1] &  idx_i[0];
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with sticky grants and a hold-time limit
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  rr_arbiter4_if.slave bus
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] SAT = '1;
  state_t st_q, st_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, dec_w, cand, others;
  logic [1:0] id_q, id_d, ptr_q, ptr_d, base, win;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic valid_q, limit, rel, found;
  dec2to4_onehot u_dec (.idx_i(id_d), .onehot_o(dec_w));
  // Pick the first requester in rotation order: from ptr when idle, from owner+1 when handing over
  always_comb begin
    others = bus.req & ~(4'b0001 << id_q);
    limit = (MAX_HOLD != 0) && (hold_q == LIM);
    rel = ~bus.req[id_q] | (limit & (|others));
    base = st_q == ST_IDLE ? ptr_q : id_q + 2'd1;
    cand = st_q == ST_IDLE ? bus.req : others;
    win = base;
    for (int k = 3; k >= 0; k--) if (cand[base + 2'(k)]) win = base + 2'(k);
    found = |cand;
  end
  // Next owner, rotation pointer and hold counter
  always_comb begin
    st_d = st_q;
    id_d = id_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    if (st_q == ST_IDLE) begin
      st_d = found ? ST_GRANT : ST_IDLE;
      id_d = found ? win : id_q;
      hold_d = '0;
    end else if (rel) begin
      ptr_d = id_q + 2'd1;
      st_d = found ? ST_GRANT : ST_IDLE;
      id_d = found ? win : id_q;
      hold_d = '0;
    end else begin
      hold_d = limit ? '0 : (hold_q == SAT ? hold_q : hold_q + CNT_W'(1));
    end
    gnt_d = st_d == ST_GRANT ? dec_w : '0;
  end
  // All outputs registered; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_IDLE;
      gnt_q <= '0;
      id_q <= '0;
      ptr_q <= '0;
      hold_q <= '0;
      valid_q <= 1'b0;
    end else begin
      st_q <= st_d;
      gnt_q <= gnt_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      valid_q <= st_d == ST_GRANT;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.gnt_id = id_q;
  assign bus.gnt_valid = valid_q;
endmodule
